uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the FIFO entry count; legal values are powers of two from 2 to 256.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the received character width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_rdy  input  1  receiver "character available" flag.
REQ-006 SHALL have port rx_data  input  DATA_W  receiver character.
REQ-007 SHALL have port rx_parity_error  input  1  parity error flag for rx_data.
REQ-008 SHALL have port rx_rdy_clr  output  1  request to the receiver to clear rx_rdy.
REQ-009 SHALL have port rd_en  input  1  pop request from the consumer.
REQ-010 SHALL have port rd_data  output  DATA_W  head-entry character, first-word-fall-through.
REQ-011 SHALL have port rd_perr  output  1  head-entry parity error flag.
REQ-012 SHALL have port empty  output  1  FIFO holds zero entries.
REQ-013 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port overrun  output  1  sticky flag: a character was dropped.
REQ-016 SHALL have port overrun_clr  input  1  clears overrun.

Function
REQ-017 SHALL implement a capture FSM with two states: IDLE and CLEAR.
REQ-018 SHALL, in IDLE with rx_rdy=1, capture {rx_parity_error, rx_data} on that edge and go to CLEAR.
REQ-019 SHALL write the capture when not full, or when full and a valid pop occurs in the same cycle (count unchanged).
REQ-020 SHALL otherwise drop the character and set overrun.
REQ-021 SHALL drive rx_rdy_clr=1, registered, for every cycle the FSM is in CLEAR.
REQ-022 SHALL leave CLEAR for IDLE on the first edge where rx_rdy=0; each rx_rdy assertion yields exactly one write or drop.
REQ-023 SHALL present the head entry on rd_data/rd_perr combinationally from storage whenever empty=0; values are don't-care when empty=1.
REQ-024 SHALL pop the head on a rising edge with rd_en=1 and empty=0; rd_en with empty=1 is ignored with no state change.
REQ-025 SHALL keep count, empty and full registered and consistent with the pointers; latency from write edge to empty=0 is one cycle.
REQ-026 SHALL increment count on write-only, decrement on pop-only, and hold it on simultaneous write and pop, including at full and empty.
REQ-027 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-028 SHALL give set priority over overrun_clr when both occur in the same cycle.

Reset
REQ-029 SHALL, with rst=1, force FSM=IDLE, pointers=0, count=0, empty=1, full=0, overrun=0 and rx_rdy_clr=0; storage contents are not reset.
REQ-030 SHALL discard any in-progress capture when reset occurs mid-operation; after reset, a still-high rx_rdy is treated as a new character.

Structure
REQ-031 SHALL take the FSM state encoding and the default DEPTH/DATA_W constants from the shared package uart_pkg.
REQ-032 SHALL place storage, pointers and count in one sub-module, uart_sync_fifo; the capture FSM and overrun flag stay in uart_rx_fifo.

Verification
REQ-033 SHALL cover single character: rx_data=0xA5 with rx_rdy held until rx_rdy_clr -> one rx_rdy_clr window; next cycle empty=0, count=1, rd_data=0xA5, rd_perr=0.
REQ-034 SHALL cover fill and overrun: 17 characters 0x00..0x10 with DEPTH=16 and no reads -> full=1, count=16, overrun=1, and pops return 0x00..0x0F in order.
REQ-035 SHALL cover simultaneous pop and write at full: rd_en pulse in the same cycle as the capture of 0x77 -> count stays 16, overrun stays 0, 0x77 is last out.
REQ-036 SHALL cover parity pass-through: character 0x3C with rx_parity_error=1 -> rd_perr=1 at the head; next character 0x3D with error 0 -> rd_perr=0.
REQ-037 SHALL cover underflow: rd_en=1 for 3 cycles while empty -> count=0, empty=1, pointers unchanged.
REQ-038 SHALL cover reset mid-capture: rst asserted in CLEAR with rx_rdy=1 -> next cycle rx_rdy_clr=0, count=0, then a fresh capture occurs.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared capture-FSM encoding and default FIFO geometry
package uart_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rx_state_e;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and consumer-side signals of the receive FIFO
interface uart_rx_fifo_if import uart_pkg::*; #(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic                     rx_rdy;
    logic [DATA_W-1:0]        rx_data;
    logic                     rx_parity_error;
    logic                     rx_rdy_clr;
    logic                     rd_en;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_perr;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overrun;
    logic                     overrun_clr;

    modport master (
        output rx_rdy, rx_data, rx_parity_error, rd_en, overrun_clr,
        input  rx_rdy_clr, rd_data, rd_perr, empty, full, count, overrun
    );

    modport slave (
        input  rx_rdy, rx_data, rx_parity_error, rd_en, overrun_clr,
        output rx_rdy_clr, rd_data, rd_perr, empty, full, count, overrun
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through FIFO with registered count/empty/full
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d, full_q, full_d;
    logic          push, pop;

    // A write at full is accepted only when a pop frees the head slot in the same cycle
    always_comb begin
        pop      = rd_en && !empty_q;
        push     = wr_en && (!full_q || pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        empty_d  = count_d == '0;
        full_d   = count_d == (AW+1)'(DEPTH);
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures receiver characters into a FIFO, handshakes rx_rdy_clr, flags overrun
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic            clk,
    input logic            rst,
    uart_rx_fifo_if.slave  bus
);

    rx_state_e         state_q, state_d;
    logic              rx_rdy_clr_q, rx_rdy_clr_d;
    logic              overrun_q, overrun_d;
    logic              wr_req, drop;
    logic [DATA_W:0]   head;

    // State and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_rdy_clr_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_rdy_clr_q <= rx_rdy_clr_d;
            overrun_q    <= overrun_d;
        end
    end

    // Capture once per rx_rdy assertion, then wait in CLEAR for the receiver to drop it
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && bus.rx_rdy) state_d = CLEAR;
        else if (state_q == CLEAR && !bus.rx_rdy) state_d = IDLE;
    end

    // Write request, drop detection and the sticky overrun flag (set beats clear)
    always_comb begin
        wr_req       = state_q == IDLE && bus.rx_rdy;
        drop         = wr_req && bus.full && !bus.rd_en;
        rx_rdy_clr_d = state_d == CLEAR;
        overrun_d    = drop ? 1'b1 : bus.overrun_clr ? 1'b0 : overrun_q;
    end

    uart_sync_fifo #(.DEPTH(DEPTH), .W(DATA_W + 1)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_req),
        .wr_data ({bus.rx_parity_error, bus.rx_data}),
        .rd_en   (bus.rd_en),
        .rd_data (head),
        .empty   (bus.empty),
        .full    (bus.full),
        .count   (bus.count)
    );

    assign bus.rd_data    = head[DATA_W-1:0];
    assign bus.rd_perr    = head[DATA_W];
    assign bus.rx_rdy_clr = rx_rdy_clr_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of capture handshake, FIFO order, overrun and reset
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(16), .DATA_W(8)) bus ();

    uart_rx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe);
        int n;
        bus.rx_data = d;
        bus.rx_parity_error = pe;
        bus.rx_rdy = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rx_rdy_clr && n < 8);
        chk("clr_rise", bus.rx_rdy_clr, 1);
        bus.rx_rdy = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.rx_rdy_clr && n < 8);
        chk("clr_fall", bus.rx_rdy_clr, 0);
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_rdy = 1'b0;
        bus.rx_data = '0;
        bus.rx_parity_error = 1'b0;
        bus.rd_en = 1'b0;
        bus.overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_clr", bus.rx_rdy_clr, 0);
        rst = 1'b0;
        @(negedge clk);

        bus.rx_data = 8'hA5;
        bus.rx_rdy = 1'b1;
        @(negedge clk);
        chk("a5_clr", bus.rx_rdy_clr, 1);
        chk("a5_empty", bus.empty, 0);
        chk("a5_count", bus.count, 1);
        chk("a5_data", bus.rd_data, 8'hA5);
        chk("a5_perr", bus.rd_perr, 0);
        bus.rx_rdy = 1'b0;
        @(negedge clk);
        chk("a5_clr_one", bus.rx_rdy_clr, 0);
        chk("a5_count_hold", bus.count, 1);
        pop();
        chk("a5_pop_empty", bus.empty, 1);
        chk("a5_pop_count", bus.count, 0);

        send(8'h3C, 1'b1);
        send(8'h3D, 1'b0);
        chk("par_count", bus.count, 2);
        chk("par_data0", bus.rd_data, 8'h3C);
        chk("par_perr0", bus.rd_perr, 1);
        pop();
        chk("par_data1", bus.rd_data, 8'h3D);
        chk("par_perr1", bus.rd_perr, 0);
        pop();
        chk("par_empty", bus.empty, 1);

        bus.rd_en = 1'b1;
        repeat (3) @(negedge clk);
        bus.rd_en = 1'b0;
        chk("uf_count", bus.count, 0);
        chk("uf_empty", bus.empty, 1);
        chk("uf_full", bus.full, 0);
        chk("uf_rdptr", dut.u_fifo.rd_ptr_q, 3);
        chk("uf_wrptr", dut.u_fifo.wr_ptr_q, 3);

        for (int i = 0; i < 17; i++) send(8'(i), 1'b0);
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 16);
        chk("fill_overrun", bus.overrun, 1);
        for (int i = 0; i < 16; i++) begin
            chk("fill_order", bus.rd_data, i);
            pop();
        end
        chk("fill_drained", bus.empty, 1);
        chk("fill_ovr_sticky", bus.overrun, 1);
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        chk("ovr_cleared", bus.overrun, 0);

        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b0);
        chk("sim_full", bus.full, 1);
        bus.rx_data = 8'h77;
        bus.rx_rdy = 1'b1;
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        bus.rx_rdy = 1'b0;
        chk("sim_count", bus.count, 16);
        chk("sim_full2", bus.full, 1);
        chk("sim_overrun", bus.overrun, 0);
        chk("sim_head", bus.rd_data, 8'h41);
        @(negedge clk);
        chk("sim_clr_fall", bus.rx_rdy_clr, 0);

        bus.rx_data = 8'h88;
        bus.rx_rdy = 1'b1;
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        bus.rx_rdy = 1'b0;
        chk("prio_overrun", bus.overrun, 1);
        chk("prio_count", bus.count, 16);
        @(negedge clk);
        for (int i = 1; i < 16; i++) begin
            chk("sim_order", bus.rd_data, 8'h40 + i);
            pop();
        end
        chk("sim_last", bus.rd_data, 8'h77);
        chk("sim_last_cnt", bus.count, 1);
        pop();
        chk("sim_empty", bus.empty, 1);

        send(8'h99, 1'b0);
        bus.rx_data = 8'h5A;
        bus.rx_rdy = 1'b1;
        @(negedge clk);
        chk("mid_clr", bus.rx_rdy_clr, 1);
        chk("mid_count", bus.count, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_clr", bus.rx_rdy_clr, 0);
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_empty", bus.empty, 1);
        chk("mid_rst_ovr", bus.overrun, 0);
        @(negedge clk);
        chk("fresh_clr", bus.rx_rdy_clr, 1);
        chk("fresh_count", bus.count, 1);
        chk("fresh_data", bus.rd_data, 8'h5A);
        bus.rx_rdy = 1'b0;
        @(negedge clk);
        chk("fresh_clr_fall", bus.rx_rdy_clr, 0);
        chk("fresh_count_hold", bus.count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
